// File: rtl/sha256_block_engine.sv
// ---------------------------------------------------------------------------
// sha256_block_engine
//
// SHA-256 compression engine for 512-bit message blocks. The hash state is
// chained across blocks, so a multi-block message is fed one block at a time.
// A block flagged blk_first restarts the chain from either the standard IV or
// the caller-supplied h_init (selected by USE_STD_IV). ROUNDS_PER_CYCLE rounds
// are evaluated per clock (1, 2 or 4). The message schedule is a 16-word
// sliding window rather than a 64-word array.
//
// Parameters:
//   ROUNDS_PER_CYCLE  rounds per clock, 1/2/4
//   USE_STD_IV        1: blk_first loads standard IV, 0: blk_first loads h_init
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   blk_valid  blk_data/blk_first/h_init valid
//   blk_ready  engine idle and able to take a block
//   blk_data   512-bit block, [511:480] = W0 ... [31:0] = W15
//   blk_first  first block of a message, reload chain before compressing
//   h_init     initial hash when USE_STD_IV=0, [255:224] = H0
//   out_valid  digest valid, held until out_ready
//   out_ready  consumer takes the digest
//   digest     chained hash after the last block, [255:224] = H0
//   busy       high while loading, compressing or finalising
// ---------------------------------------------------------------------------
module sha256_block_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit USE_STD_IV       = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic [255:0] h_init,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest,
    output logic         busy
);

    localparam int R = ROUNDS_PER_CYCLE;

    // Counter value seen during the last ROUND cycle.
    localparam logic [6:0] LAST_CNT = 7'(64 - R);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ROUND  = 3'd2;
    localparam logic [2:0] S_FINAL  = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
            $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Index 0 is H0 / a / W0 throughout.
    typedef logic [7:0][31:0]  hash_t;
    typedef logic [15:0][31:0] win_t;

    localparam hash_t STD_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ------------------------------------------------------------------
    // SHA-256 primitives
    // ------------------------------------------------------------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic hash_t from_flat(input logic [255:0] f);
        hash_t h;
        for (int i = 0; i < 8; i++) begin
            h[i] = f[255 - 32*i -: 32];
        end
        return h;
    endfunction

    function automatic logic [255:0] to_flat(input hash_t h);
        logic [255:0] f;
        for (int i = 0; i < 8; i++) begin
            f[255 - 32*i -: 32] = h[i];
        end
        return f;
    endfunction

    function automatic win_t unpack_block(input logic [511:0] b);
        win_t w;
        for (int i = 0; i < 16; i++) begin
            w[i] = b[511 - 32*i -: 32];
        end
        return w;
    endfunction

    // Slide the schedule window by R words. New words are produced in order,
    // so later new words may depend on earlier ones within the same cycle.
    // Near the end of the block this computes words past W63; they are never used.
    function automatic win_t next_window(input win_t w);
        logic [19:0][31:0] ext;
        win_t              nw;
        ext = '0;
        for (int i = 0; i < 16; i++) begin
            ext[i] = w[i];
        end
        for (int k = 0; k < R; k++) begin
            ext[16 + k] = ssig1(ext[14 + k]) + ext[9 + k] + ssig0(ext[1 + k]) + ext[k];
        end
        for (int i = 0; i < 16; i++) begin
            nw[i] = ext[i + R];
        end
        return nw;
    endfunction

    // Apply R rounds back to back. Round j of this cycle is round t0+j and
    // uses window word j, which is always one of the current 16 words.
    function automatic hash_t do_rounds(input hash_t s, input win_t w, input logic [5:0] t0);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        hash_t       o;
        a = s[0]; b = s[1]; c = s[2]; d = s[3];
        e = s[4]; f = s[5]; g = s[6]; h = s[7];
        for (int j = 0; j < R; j++) begin
            t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[t0 + 6'(j)] + w[j];
            t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
            h = g;
            g = f;
            f = e;
            e = d + t1;
            d = c;
            c = b;
            b = a;
            a = t1 + t2;
        end
        o[0] = a; o[1] = b; o[2] = c; o[3] = d;
        o[4] = e; o[5] = f; o[6] = g; o[7] = h;
        return o;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0] state;
    logic [6:0] round_cnt;
    hash_t      chain_h;
    hash_t      base_h;
    hash_t      work;
    hash_t      digest_q;
    win_t       win;

    hash_t      work_next;
    win_t       win_next;
    hash_t      final_sum;
    logic       accept;

    // rstn gates blk_ready directly so it is low for the whole reset pulse.
    assign blk_ready = rstn && (state == S_IDLE);
    assign accept    = blk_valid && blk_ready;
    assign out_valid = (state == S_OUTPUT);
    assign busy      = (state == S_LOAD) || (state == S_ROUND) || (state == S_FINAL);
    assign digest    = to_flat(digest_q);

    assign work_next = do_rounds(work, win, round_cnt[5:0]);
    assign win_next  = next_window(win);

    always_comb begin
        final_sum = '0;
        for (int i = 0; i < 8; i++) begin
            final_sum[i] = base_h[i] + work[i];
        end
    end

    // Block, first flag and h_init are only guaranteed on the accept edge, so
    // the window and the base hash are captured right there; LOAD then seeds
    // the working variables from the captured base.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            round_cnt <= '0;
            chain_h   <= STD_IV;
            base_h    <= '0;
            work      <= '0;
            digest_q  <= '0;
            win       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        win <= unpack_block(blk_data);
                        if (blk_first) begin
                            base_h <= USE_STD_IV ? STD_IV : from_flat(h_init);
                        end else begin
                            base_h <= chain_h;
                        end
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    work      <= base_h;
                    round_cnt <= '0;
                    state     <= S_ROUND;
                end
                S_ROUND: begin
                    work      <= work_next;
                    win       <= win_next;
                    round_cnt <= round_cnt + 7'(R);
                    if (round_cnt == LAST_CNT) begin
                        state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    chain_h  <= final_sum;
                    digest_q <= final_sum;
                    state    <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_engine.sv
// ---------------------------------------------------------------------------
// tb_sha256_block_engine
//
// Four engine instances: R=1, R=2, R=4 with the standard IV, and R=1 with
// caller-supplied h_init. Known-answer vectors plus random blocks are checked
// against a plain SHA-256 compression model with a 64-word schedule.
// ---------------------------------------------------------------------------
module tb_sha256_block_engine;

    localparam int NDUT = 4;

    localparam logic [255:0] STD_IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         blk_valid_s [NDUT];
    logic         blk_ready_s [NDUT];
    logic [511:0] blk_data_s  [NDUT];
    logic         blk_first_s [NDUT];
    logic [255:0] h_init_s    [NDUT];
    logic         out_valid_s [NDUT];
    logic         out_ready_s [NDUT];
    logic [255:0] digest_s    [NDUT];
    logic         busy_s      [NDUT];

    logic [255:0] model_chain [NDUT];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            sha256_block_engine #(
                .ROUNDS_PER_CYCLE((g == 1) ? 2 : ((g == 2) ? 4 : 1)),
                .USE_STD_IV      ((g == 3) ? 1'b0 : 1'b1)
            ) u_dut (
                .clk       (clk),
                .rstn      (rstn),
                .blk_valid (blk_valid_s[g]),
                .blk_ready (blk_ready_s[g]),
                .blk_data  (blk_data_s[g]),
                .blk_first (blk_first_s[g]),
                .h_init    (h_init_s[g]),
                .out_valid (out_valid_s[g]),
                .out_ready (out_ready_s[g]),
                .digest    (digest_s[g]),
                .busy      (busy_s[g])
            );
        end
    endgenerate

    function automatic int rpc_of(input int d);
        return (d == 1) ? 2 : ((d == 2) ? 4 : 1);
    endfunction

    // Reference model: textbook compression with a full 64-word schedule.
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  hv [8];
        logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32*i -: 32];
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
        hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = $urandom();
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One full block transaction on instance d, checked against the model.
    task automatic applyStimulus(input int d, input logic [511:0] blk, input logic first,
                                 input logic [255:0] hinit, input int hold, input string tag,
                                 output logic [255:0] got);
        logic [255:0] base;
        logic [255:0] exp;
        logic [255:0] held;
        int           waitc;
        int           lat;
        base = first ? ((d == 3) ? hinit : STD_IV) : model_chain[d];
        exp  = sha_compress(base, blk);
        model_chain[d] = exp;

        @(negedge clk);
        waitc = 0;
        while (!blk_ready_s[d] && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!blk_ready_s[d]) checkOutput({tag, "_ready_timeout"}, 256'(blk_ready_s[d]), 256'(1));

        blk_valid_s[d] = 1'b1;
        blk_data_s[d]  = blk;
        blk_first_s[d] = first;
        h_init_s[d]    = hinit;
        @(posedge clk);
        #1;
        blk_valid_s[d] = 1'b0;
        blk_data_s[d]  = rand512();
        h_init_s[d]    = rand256();
        blk_first_s[d] = 1'($urandom_range(0, 1));
        checkOutput({tag, "_busy_load"}, 256'(busy_s[d]), 256'(1));

        lat = 0;
        while (!out_valid_s[d] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 256'(lat), 256'(64 / rpc_of(d) + 2));
        checkOutput({tag, "_digest"}, digest_s[d], exp);
        checkOutput({tag, "_busy_out"}, 256'(busy_s[d]), 256'(0));
        got  = digest_s[d];
        held = digest_s[d];

        for (int i = 0; i < hold; i++) begin
            blk_valid_s[d] = 1'b1;
            out_ready_s[d] = 1'b0;
            @(posedge clk);
            #1;
            checkOutput({tag, "_hold_digest"}, digest_s[d], held);
            checkOutput({tag, "_hold_flags"}, 256'({out_valid_s[d], blk_ready_s[d]}), 256'(2'b10));
        end

        blk_valid_s[d] = 1'b0;
        out_ready_s[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[d] = 1'b0;
        checkOutput({tag, "_release"}, 256'({out_valid_s[d], blk_ready_s[d]}), 256'(2'b01));
    endtask

    initial begin
        logic [255:0] got;
        logic [255:0] mid;
        int           ovc;
        logic         f;

        for (int d = 0; d < NDUT; d++) begin
            blk_valid_s[d] = 1'b0;
            blk_data_s[d]  = '0;
            blk_first_s[d] = 1'b0;
            h_init_s[d]    = '0;
            out_ready_s[d] = 1'b0;
            model_chain[d] = STD_IV;
        end

        // Reset state
        rstn = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("rst_flags", 256'({blk_ready_s[d], out_valid_s[d], busy_s[d]}), 256'(3'b000));
            checkOutput("rst_digest", digest_s[d], 256'(0));
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("rst_release_ready", 256'(blk_ready_s[d]), 256'(1));
        end

        // Standard-IV instances: known answers, chaining, backpressure, random
        for (int d = 0; d < 3; d++) begin
            $display("[TB] instance %0d, %0d rounds per cycle", d, rpc_of(d));
            applyStimulus(d, B_ABC, 1'b1, '0, (d == 0) ? 20 : 2, "abc", got);
            checkOutput("abc_kat", got, D_ABC);
            applyStimulus(d, B_EMPTY, 1'b1, '0, 0, "empty", got);
            checkOutput("empty_kat", got, D_EMPTY);
            applyStimulus(d, B_TWO1, 1'b1, '0, 0, "two_blk1", got);
            applyStimulus(d, B_TWO2, 1'b0, '0, 1, "two_blk2", got);
            checkOutput("two_kat", got, D_TWO);
            applyStimulus(d, B_ABC, 1'b1, '0, 0, "abc_reload", got);
            checkOutput("abc_reload_kat", got, D_ABC);
            for (int n = 0; n < 6; n++) begin
                f = 1'($urandom_range(0, 1));
                applyStimulus(d, rand512(), f, rand256(), $urandom_range(0, 3), "rand", got);
            end
        end

        // Caller-midstate instance
        $display("[TB] instance 3, h_init path");
        applyStimulus(3, B_ABC, 1'b1, STD_IV, 0, "hinit_abc", got);
        checkOutput("hinit_abc_kat", got, D_ABC);
        mid = sha_compress(STD_IV, B_TWO1);
        applyStimulus(3, B_TWO2, 1'b1, mid, 0, "hinit_mid", got);
        checkOutput("hinit_mid_kat", got, D_TWO);
        for (int n = 0; n < 6; n++) begin
            f = 1'($urandom_range(0, 1));
            applyStimulus(3, rand512(), f, rand256(), $urandom_range(0, 3), "hinit_rand", got);
        end

        // Abort in the middle of the rounds on instance 0
        @(negedge clk);
        blk_valid_s[0] = 1'b1;
        blk_data_s[0]  = B_EMPTY;
        blk_first_s[0] = 1'b1;
        @(posedge clk);
        #1;
        blk_valid_s[0] = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        checkOutput("abort_pre_busy", 256'({busy_s[0], out_valid_s[0]}), 256'(2'b10));
        rstn = 1'b0;
        #1;
        checkOutput("abort_flags", 256'({out_valid_s[0], busy_s[0], blk_ready_s[0]}), 256'(3'b000));
        checkOutput("abort_digest", digest_s[0], 256'(0));
        for (int d = 0; d < NDUT; d++) model_chain[d] = STD_IV;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("abort_release", 256'({blk_ready_s[0], busy_s[0], out_valid_s[0]}), 256'(3'b100));
        ovc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid_s[0]) ovc++;
        end
        checkOutput("abort_no_output", 256'(ovc), 256'(0));
        applyStimulus(0, B_ABC, 1'b0, '0, 0, "abort_abc", got);
        checkOutput("abort_abc_kat", got, D_ABC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha256_block_engine.md
Name: sha256_block_engine

Overview:
Parametrised SHA-256 compression engine; next generation of the team's single-block processor. Accepts 512-bit message blocks over a valid/ready handshake and chains the hash state across blocks for multi-block messages, with a selectable initial hash per message (standard IV or caller midstate). Runs 1, 2 or 4 rounds per cycle. Returns the 256-bit digest over a valid/ready output handshake with backpressure. Sits between the message padder and the digest consumer.

Parameters:
ROUNDS_PER_CYCLE, 1, rounds per clock; legal values 1, 2, 4; any other value is an elaboration error.
USE_STD_IV, 1, 1: blk_first loads the standard SHA-256 IV; 0: blk_first loads h_init.

Ports:
clk  in  1  clock; all state changes on its rising edge
rstn  in  1  asynchronous active-low reset
blk_valid  in  1  blk_data/blk_first valid
blk_ready  out  1  engine can accept a block
blk_data  in  512  message block; [511:480]=W0 ... [31:0]=W15
blk_first  in  1  first block of a message; chain state is reloaded before compression
h_init  in  256  initial hash when USE_STD_IV=0; [255:224]=H0 ... [31:0]=H7
out_valid  out  1  digest valid
out_ready  in  1  consumer accepts digest
digest  out  256  chained hash after the last accepted block; [255:224]=H0
busy  out  1  high in LOAD, ROUND or FINAL

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, blk_ready=0 while rstn is low, out_valid=0, busy=0, digest=0, round counter=0, chain H=standard IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19). After reset release, blk_ready=1 from the first cycle.
- Abort: reset asserted mid-operation discards the block in flight. No output is produced for it.
- States:
  - IDLE: blk_ready=1. On blk_valid&&blk_ready, go to LOAD.
  - LOAD: 1 cycle. Base H := blk_first ? (USE_STD_IV ? IV : h_init) : chain H. Set a..h := base. Load the 16-word W window from blk_data; h_init/blk_data sampled at the accept edge.
  - ROUND: 64/ROUNDS_PER_CYCLE cycles. Each cycle applies ROUNDS_PER_CYCLE rounds in combinational sequence. The message schedule is a 16-word sliding window shifted by ROUNDS_PER_CYCLE words per cycle; there is no 64-entry W array. Round t uses W[t] and K[t], t=0..63. The counter increments by ROUNDS_PER_CYCLE.
  - FINAL: 1 cycle. Chain H := base + {a..h}, each word mod 2^32, and digest := the new chain H.
  - OUTPUT: out_valid=1 with digest stable. On out_valid&&out_ready, go to IDLE.
- Handshake latency:
  - Accept edge T. LOAD at T+1. Rounds finish at T+1+64/R. FINAL writes at T+2+64/R, so out_valid is high from that edge.
  - R=1: 66 cycles. R=2: 34. R=4: 18.
- Input side: blk_ready=0 in every state except IDLE, so at most one block is in flight. blk_data and h_init need only be valid on the accept edge.
- Output hold: out_valid, once high, stays high and digest stays unchanged until accepted. out_ready while out_valid=0 is ignored.
- Digest persistence: digest and chain H persist after acceptance. The next block with blk_first=0 continues the chain.
- blk_first=0 as the first block after reset compresses from the standard IV (chain reset value).
- All additions wrap mod 2^32; rotations are 32-bit.

Test Plan:
- "abc" single block (padded 61626380 00..00 00000018), blk_first=1, USE_STD_IV=1, R=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid exactly 66 cycles after the accept edge. Repeat with R=2 and R=4 -> same digest at 34 and 18 cycles.
- Empty message (80000000, zeros, length 0), blk_first=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block1 blk_first=1, block2 blk_first=0 -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Then resend "abc" with blk_first=1 -> ba7816bf...f20015ad, showing the chain is reloaded.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> digest constant, blk_ready=0, and blk_valid=1 is not accepted; out_ready=1 for one cycle -> out_valid=0 and blk_ready=1 the next cycle.
- USE_STD_IV=0, h_init=standard IV, "abc" with blk_first=1 -> identical to the first test. h_init = chain H after block1 of the two-block test, block2 sent with blk_first=1 -> 248d6a61...19db06c1.
- Assert rstn low at ROUND cycle 30 -> out_valid=0, busy=0, blk_ready=1 after release. A following "abc" with blk_first=0 -> ba7816bf..., showing the chain was reset to the IV.
